// File: rtl/rv_wb_timer.sv
// Wishbone classic responder exposing the RISC-V machine timer (mtime/mtimecmp)
// and a registered machine timer interrupt.
module rv_wb_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  input  logic        i_wb_cyc,
  output logic        o_irq
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  localparam logic [3:0] WcntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        latch_en;
  logic [2:0]  off_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] wdat_q;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  presc_q, presc_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        irq_q, irq_d;

  logic        req;
  logic        ack;
  logic        commit;
  logic        tick;
  logic [31:0] wmask;
  logic [31:0] rdata;

  assign req = i_wb_cyc & i_wb_stb & (i_wb_adr[31:5] == BASE_ADDR[31:5]);
  assign ack = (state_q == StAck);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          latch_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            wcnt_d  = WcntInit;
          end
        end
      end
      StWait: begin
        // Initiator withdrew the cycle: drop the request without side effects.
        if (!i_wb_cyc) begin
          state_d = StIdle;
        end else if (wcnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      off_q   <= 3'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (latch_en) begin
        off_q  <= i_wb_adr[4:2];
        we_q   <= i_wb_we;
        sel_q  <= i_wb_sel;
        wdat_q <= i_wb_dat;
      end
    end
  end

  assign commit = ack & we_q;
  assign wmask  = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
  assign tick   = en_q & (presc_q == div_q);

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    div_d       = div_q;
    presc_d     = presc_q;
    hi_shadow_d = hi_shadow_q;
    irq_d       = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
      if (tick) mtime_d = mtime_q + 64'd1;
    end

    // Bus writes override the increment; unwritten lanes keep the live value.
    if (commit) begin
      case (off_q)
        3'd0: mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~wmask) | (wdat_q & wmask)};
        3'd1: mtime_d = {(mtime_q[63:32] & ~wmask) | (wdat_q & wmask), mtime_q[31:0]};
        3'd2: mtimecmp_d = {mtimecmp_q[63:32],
                            (mtimecmp_q[31:0] & ~wmask) | (wdat_q & wmask)};
        3'd3: mtimecmp_d = {(mtimecmp_q[63:32] & ~wmask) | (wdat_q & wmask),
                            mtimecmp_q[31:0]};
        3'd4: begin
          if (sel_q[0]) en_d = wdat_q[0];
          if (sel_q[1]) div_d = wdat_q[15:8];
          presc_d = 8'd0;
        end
        default: ;
      endcase
    end

    if (ack && !we_q && (off_q == 3'd0)) hi_shadow_d = mtime_q[63:32];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q        <= 1'b1;
      div_q       <= 8'd0;
      presc_q     <= 8'd0;
      hi_shadow_q <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      hi_shadow_q <= hi_shadow_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (off_q)
      3'd0:    rdata = mtime_q[31:0];
      3'd1:    rdata = hi_shadow_q;
      3'd2:    rdata = mtimecmp_q[31:0];
      3'd3:    rdata = mtimecmp_q[63:32];
      3'd4:    rdata = {16'd0, div_q, 7'd0, en_q};
      3'd5:    rdata = {31'd0, irq_q};
      default: rdata = 32'd0;
    endcase
  end

  assign o_wb_ack = ack;
  assign o_wb_dat = ack ? rdata : 32'd0;
  assign o_irq    = irq_q;

endmodule
